writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL provide parameter RETIRE_W, default 32, width of retired-instruction counter.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  upstream memory stage presents an instruction.
REQ-005 SHALL provide port in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 SHALL provide port in_rd_id  input  5  destination register index.
REQ-007 SHALL provide port in_reg_write  input  1  instruction writes a register.
REQ-008 SHALL provide port in_mem_to_reg  input  1  instruction is a load; result comes from memory.
REQ-009 SHALL provide port in_funct3  input  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-010 SHALL provide port in_alu_result  input  32  ALU result, or load byte address for loads.
REQ-011 SHALL provide port mem_rvalid  input  1  data memory returns the load word.
REQ-012 SHALL provide port mem_rdata  input  32  aligned 32-bit load word.
REQ-013 SHALL provide port write_en, write_id[5], write_data[32]  output  register-file write port.
REQ-014 SHALL provide port load_err  output  1  one-cycle pulse on illegal or misaligned load.
REQ-015 SHALL provide port retire_count  output  RETIRE_W  completed-instruction count.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_MEM, WRITE; in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM.
REQ-017 SHALL accept when in_valid & in_ready; capture rd_id, reg_write, mem_to_reg, funct3, alu_result.
REQ-018 Non-load accepted in cycle N SHALL go to WRITE, with write_en/write_id/write_data valid in cycle N+1; write_data = captured alu_result.
REQ-019 Load accepted in cycle N SHALL go to WAIT_MEM; mem_rvalid SHALL be sampled only in WAIT_MEM (ignored in IDLE/WRITE and in the accept cycle).
REQ-020 mem_rvalid in WAIT_MEM cycle M SHALL go to WRITE; write port valid in cycle M+1; no timeout.
REQ-021 Load extraction uses offset = captured alu_result[1:0]: LB/LBU byte at offset sign/zero-extended; LH/LHU halfword at offset[1] sign/zero-extended; LW full word.
REQ-022 Misaligned loads SHALL give load_err in the WRITE cycle and no write: LH/LHU with offset[0]=1, LW with offset != 0, funct3 in {011,110,111}.
REQ-023 write_en SHALL be 1 only in WRITE, only if reg_write=1, rd_id != 0 and no load_err; write_id/write_data SHALL be 0 whenever write_en=0.
REQ-024 retire_count SHALL increment by 1 on every WRITE cycle, including suppressed writes and load_err, and wrap modulo 2^RETIRE_W.
REQ-025 WRITE with a new acceptance SHALL go to WRITE (non-load) or WAIT_MEM (load), sustaining one ALU instruction per cycle; otherwise WRITE SHALL go to IDLE.
REQ-026 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-027 reset_n=0 at a posedge SHALL force IDLE, write_en=0, write_id=0, write_data=0, load_err=0, retire_count=0 next cycle, from any state.
REQ-028 Reset during WAIT_MEM SHALL drop the pending load; a later mem_rvalid SHALL produce no write.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-030 ALU op rd=5, alu_result=0x0000_1234 accepted cycle N -> write_en=1, write_id=5, write_data=0x1234 in N+1; retire_count=1.
REQ-031 LB rd=3, addr offset 2, mem_rdata=0x0080_0000 after 3 wait cycles -> in_ready=0 while waiting; write_data=0xFFFF_FF80 one cycle after mem_rvalid. LBU with same data -> 0x0000_0080.
REQ-032 LW at offset 1 -> load_err pulse, write_en=0, retire_count increments; LH rd=0 aligned -> no write, no error.
REQ-033 Back-to-back ALU ops rd=1..4 on consecutive cycles -> four consecutive write cycles; in_ready stays 1; retire_count=4.
REQ-034 Reset asserted in WAIT_MEM, mem_rvalid pulsed after release -> no write_en; retire_count=0.
REQ-035 Preset retire_count to 2^RETIRE_W-1 (RETIRE_W=4), complete one instruction -> retire_count=0.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. It accepts one instruction from the memory stage,
// waits for load data if needed, and produces a single register-file write.
// Load results are extracted (byte/halfword/word, signed/unsigned) from the
// aligned memory word. Misaligned or illegal loads raise load_err instead of
// writing. Every completed instruction bumps retire_count.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid / in_ready     handshake with the memory stage
//   in_rd_id, in_reg_write, in_mem_to_reg, in_funct3, in_alu_result
//                           instruction fields captured on acceptance
//   mem_rvalid, mem_rdata   load word returned by data memory
//   write_en, write_id, write_data
//                           register-file write port (id/data zero when idle)
//   load_err                one-cycle pulse for a misaligned/illegal load
//   retire_count            completed-instruction counter (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_rd_id,
    input  logic                in_reg_write,
    input  logic                in_mem_to_reg,
    input  logic [2:0]          in_funct3,
    input  logic [31:0]         in_alu_result,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic                write_en,
    output logic [4:0]          write_id,
    output logic [31:0]         write_data,
    output logic                load_err,
    output logic [RETIRE_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t state, state_nx;

    logic [4:0]          rd_id_q;
    logic                reg_write_q;
    logic                mem_to_reg_q;
    logic [2:0]          funct3_q;
    logic [31:0]         alu_result_q;
    logic [31:0]         mem_word_q;
    logic [RETIRE_W-1:0] retire_q;

    logic                accept;
    logic [1:0]          offset;
    logic [31:0]         byte_shifted;
    logic [7:0]          load_byte;
    logic [15:0]         load_half;
    logic [31:0]         load_value;
    logic                misaligned;
    logic [31:0]         result;

    // ---------------------------------------------------------------- control
    // in_ready depends only on state, so upstream never sees a comb loop.
    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // NOTE: every signal assigned in an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = in_mem_to_reg ? WAIT_MEM : WRITE;
            end
            WAIT_MEM: begin
                if (mem_rvalid) state_nx = WRITE;
            end
            WRITE: begin
                if (accept) state_nx = in_mem_to_reg ? WAIT_MEM : WRITE;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rd_id_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            funct3_q     <= '0;
            alu_result_q <= '0;
            mem_word_q   <= '0;
            retire_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rd_id_q      <= in_rd_id;
                reg_write_q  <= in_reg_write;
                mem_to_reg_q <= in_mem_to_reg;
                funct3_q     <= in_funct3;
                alu_result_q <= in_alu_result;
            end
            // Load data is only meaningful while a load is outstanding.
            if (state == WAIT_MEM && mem_rvalid) mem_word_q <= mem_rdata;
            // Count at the edge that closes each WRITE cycle, suppressed or not.
            if (state == WRITE) retire_q <= retire_q + RETIRE_W'(1);
        end
    end

    // --------------------------------------------------------------- datapath
    assign offset       = alu_result_q[1:0];
    assign byte_shifted = mem_word_q >> {offset, 3'b000};
    assign load_byte    = byte_shifted[7:0];
    assign load_half    = offset[1] ? mem_word_q[31:16] : mem_word_q[15:0];

    always_comb begin
        load_value = '0;
        misaligned = 1'b0;
        case (funct3_q)
            3'b000: load_value = {{24{load_byte[7]}}, load_byte};
            3'b100: load_value = {24'h0, load_byte};
            3'b001: begin
                load_value = {{16{load_half[15]}}, load_half};
                misaligned = offset[0];
            end
            3'b101: begin
                load_value = {16'h0, load_half};
                misaligned = offset[0];
            end
            3'b010: begin
                load_value = mem_word_q;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;   // 011/110/111 are not loads
        endcase
    end

    assign result   = mem_to_reg_q ? load_value : alu_result_q;
    assign load_err = (state == WRITE) && mem_to_reg_q && misaligned;
    assign write_en = (state == WRITE) && reg_write_q && (rd_id_q != 5'd0) && !load_err;

    // Idle write port is driven to zero so downstream never sees stale data.
    assign write_id     = write_en ? rd_id_q : 5'd0;
    assign write_data   = write_en ? result  : 32'd0;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage (RETIRE_W = 4 so counter wrap is cheap).
// Single-instruction cases come from a vector table; multi-cycle corners
// (long memory wait, back-to-back issue, counter wrap, reset mid-load) are
// hand-written sequences. Inputs change 1 ns after posedge; outputs are
// sampled in that same window, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rd_id;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic [2:0]    in_funct3;
    logic [31:0]   in_alu_result;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          write_en;
    logic [4:0]    write_id;
    logic [31:0]   write_data;
    logic          load_err;
    logic [RW-1:0] retire_count;

    int tests  = 0;
    int failed = 0;
    logic [RW-1:0] exp_rc;

    writeback_stage #(.RETIRE_W(RW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd_id      (in_rd_id),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .write_en      (write_en),
        .write_id      (write_id),
        .write_data    (write_data),
        .load_err      (load_err),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_load;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic [31:0] alu);
        in_valid      = 1'b1;
        in_mem_to_reg = ld;
        in_funct3     = f3;
        in_rd_id      = rd;
        in_reg_write  = rw;
        in_alu_result = alu;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_mem_to_reg = 1'b0;
        in_funct3     = 3'b000;
        in_rd_id      = 5'd0;
        in_reg_write  = 1'b0;
        in_alu_result = 32'd0;
    endtask

    function automatic vec_t mk(input string name, input logic ld, input logic [2:0] f3,
                                input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                                input logic [31:0] mdata, input logic we,
                                input logic [31:0] data, input logic err);
        vec_t v;
        v.name = name; v.is_load = ld; v.f3 = f3; v.rd = rd; v.rw = rw;
        v.alu = alu; v.mdata = mdata; v.exp_we = we; v.exp_data = data; v.exp_err = err;
        return v;
    endfunction

    // One instruction from IDLE: accept, optional single memory wait, write, back to IDLE.
    task automatic run_vec(input vec_t v);
        drive(v.is_load, v.f3, v.rd, v.rw, v.alu);
        check({v.name, ".ready_accept"}, 32'(in_ready), 32'd1);
        tick();
        idle_inputs();
        if (v.is_load) begin
            check({v.name, ".ready_wait"}, 32'(in_ready), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.mdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end
        check({v.name, ".write_en"},   32'(write_en), 32'(v.exp_we));
        check({v.name, ".write_id"},   32'(write_id), v.exp_we ? 32'(v.rd) : 32'd0);
        check({v.name, ".write_data"}, write_data,    v.exp_we ? v.exp_data : 32'd0);
        check({v.name, ".load_err"},   32'(load_err), 32'(v.exp_err));
        tick();
        exp_rc++;
        check({v.name, ".retire"},     32'(retire_count), 32'(exp_rc));
        check({v.name, ".err_pulse"},  32'(load_err), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk("alu_rd5",      1'b0, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 32'h0,         1'b1, 32'h0000_1234, 1'b0);
        vecs[1]  = mk("lb_off2",      1'b1, 3'b000, 5'd3,  1'b1, 32'h0000_1002, 32'h0080_0000, 1'b1, 32'hFFFF_FF80, 1'b0);
        vecs[2]  = mk("lbu_off2",     1'b1, 3'b100, 5'd3,  1'b1, 32'h0000_1002, 32'h0080_0000, 1'b1, 32'h0000_0080, 1'b0);
        vecs[3]  = mk("lb_off1",      1'b1, 3'b000, 5'd6,  1'b1, 32'h0000_0041, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0);
        vecs[4]  = mk("lb_off3",      1'b1, 3'b000, 5'd6,  1'b1, 32'h0000_0043, 32'hA500_0000, 1'b1, 32'hFFFF_FFA5, 1'b0);
        vecs[5]  = mk("lbu_off0",     1'b1, 3'b100, 5'd7,  1'b1, 32'h0000_0040, 32'h0000_00FF, 1'b1, 32'h0000_00FF, 1'b0);
        vecs[6]  = mk("lh_off2",      1'b1, 3'b001, 5'd8,  1'b1, 32'h0000_0082, 32'h8001_7F00, 1'b1, 32'hFFFF_8001, 1'b0);
        vecs[7]  = mk("lhu_off0",     1'b1, 3'b101, 5'd9,  1'b1, 32'h0000_0080, 32'h1234_F00D, 1'b1, 32'h0000_F00D, 1'b0);
        vecs[8]  = mk("lw_off0",      1'b1, 3'b010, 5'd10, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
        vecs[9]  = mk("lw_off1_err",  1'b1, 3'b010, 5'd10, 1'b1, 32'h0000_0101, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1);
        vecs[10] = mk("lh_rd0",       1'b1, 3'b001, 5'd0,  1'b1, 32'h0000_0100, 32'h0000_5555, 1'b0, 32'h0,         1'b0);
        vecs[11] = mk("lh_off3_err",  1'b1, 3'b001, 5'd11, 1'b1, 32'h0000_0103, 32'h1111_2222, 1'b0, 32'h0,         1'b1);
        vecs[12] = mk("lhu_off1_err", 1'b1, 3'b101, 5'd11, 1'b1, 32'h0000_0101, 32'h1111_2222, 1'b0, 32'h0,         1'b1);
        vecs[13] = mk("f3_011_err",   1'b1, 3'b011, 5'd12, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b0, 32'h0,         1'b1);
        vecs[14] = mk("f3_110_err",   1'b1, 3'b110, 5'd12, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b0, 32'h0,         1'b1);
        vecs[15] = mk("f3_111_err",   1'b1, 3'b111, 5'd12, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b0, 32'h0,         1'b1);
        vecs[16] = mk("alu_no_rw",    1'b0, 3'b000, 5'd13, 1'b0, 32'h0000_ABCD, 32'h0,         1'b0, 32'h0,         1'b0);
        vecs[17] = mk("alu_rd31_f3x", 1'b0, 3'b111, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0);

        // ------------------------------------------------------------ reset
        reset_n    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        idle_inputs();
        exp_rc = '0;
        tick();
        tick();
        check("rst.write_en",   32'(write_en),     32'd0);
        check("rst.write_id",   32'(write_id),     32'd0);
        check("rst.write_data", write_data,        32'd0);
        check("rst.load_err",   32'(load_err),     32'd0);
        check("rst.retire",     32'(retire_count), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst.ready_after", 32'(in_ready), 32'd1);

        // ------------------------------------------------------------ table
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---------------------------- LB with three empty wait cycles
        // mem_rvalid in the accept cycle must be ignored.
        drive(1'b1, 3'b000, 5'd3, 1'b1, 32'h0000_2002);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        idle_inputs();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        for (int w = 0; w < 3; w++) begin
            check("lbwait.ready", 32'(in_ready), 32'd0);
            check("lbwait.no_we", 32'(write_en), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0080_0000;
        check("lbwait.ready_last", 32'(in_ready), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        check("lbwait.write_en",   32'(write_en), 32'd1);
        check("lbwait.write_id",   32'(write_id), 32'd3);
        check("lbwait.write_data", write_data,    32'hFFFF_FF80);
        tick();
        exp_rc++;

        // ---------------------------- mem_rvalid while IDLE is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        check("idle_rvalid.no_we", 32'(write_en), 32'd0);
        check("idle_rvalid.ready", 32'(in_ready), 32'd1);
        tick();
        check("idle_rvalid.no_we2", 32'(write_en), 32'd0);

        // ---------------------------- back-to-back ALU rd1..4, then a load
        drive(1'b0, 3'b000, 5'd1, 1'b1, 32'h0000_0101);
        tick();
        for (int r = 2; r <= 4; r++) begin
            check("b2b.ready",    32'(in_ready),   32'd1);
            check("b2b.write_en", 32'(write_en),   32'd1);
            check("b2b.write_id", 32'(write_id),   32'(r - 1));
            check("b2b.data",     write_data,      32'h100 + 32'(r - 1));
            drive(1'b0, 3'b000, 5'(r), 1'b1, 32'h100 + 32'(r));
            tick();
        end
        check("b2b.ready4",    32'(in_ready), 32'd1);
        check("b2b.write_id4", 32'(write_id), 32'd4);
        drive(1'b1, 3'b010, 5'd7, 1'b1, 32'h0000_0200);
        tick();
        idle_inputs();
        exp_rc = exp_rc + RW'(4);
        check("b2b.ready_wait", 32'(in_ready),     32'd0);
        check("b2b.retire",     32'(retire_count), 32'(exp_rc));
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check("b2b.load_id",   32'(write_id), 32'd7);
        check("b2b.load_data", write_data,    32'hCAFE_F00D);
        tick();
        exp_rc++;

        // ---------------------------- retire_count wrap at 2^RW
        for (int k = 0; k < 16 && exp_rc != RW'(15); k++) begin
            drive(1'b0, 3'b000, 5'd2, 1'b1, 32'(k));
            tick();
            idle_inputs();
            tick();
            exp_rc++;
        end
        check("wrap.at_max", 32'(retire_count), 32'd15);
        drive(1'b0, 3'b000, 5'd2, 1'b1, 32'h77);
        tick();
        idle_inputs();
        tick();
        check("wrap.to_zero", 32'(retire_count), 32'd0);

        // ---------------------------- reset while WAIT_MEM drops the load
        drive(1'b1, 3'b010, 5'd9, 1'b1, 32'h0000_0300);
        tick();
        idle_inputs();
        check("rstwait.ready_wait", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstwait.ready_after", 32'(in_ready),     32'd1);
        check("rstwait.retire",      32'(retire_count), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check("rstwait.no_we", 32'(write_en), 32'd0);
        tick();
        check("rstwait.no_we2",  32'(write_en),     32'd0);
        check("rstwait.retire2", 32'(retire_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
